// File: rtl/exec_datapath.sv
// rtl/exec_datapath.sv - execute-stage datapath: registered adder, RV32I ALU and machine-mode CSR file
module exec_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic        add_en,
  input  logic [31:0] add_a,
  input  logic [31:0] add_b,
  output logic [31:0] add_sum,
  input  logic        alu_en,
  input  logic [4:0]  alu_op,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  output logic [31:0] alu_out,
  output logic        alu_fault,
  input  logic        csr_en,
  input  logic [2:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_in,
  output logic [31:0] csr_read_value,
  output logic        csr_fault,
  output logic        fault
);

  localparam logic [2:0] CSR_READ  = 3'd0;
  localparam logic [2:0] CSR_WRITE = 3'd1;
  localparam logic [2:0] CSR_SET   = 3'd2;
  localparam logic [2:0] CSR_CLEAR = 3'd3;

  logic [31:0] add_sum_q, add_sum_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic        alu_fault_q, alu_fault_d;
  logic [31:0] csr_rd_q, csr_rd_d;
  logic        csr_fault_q, csr_fault_d;

  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

  // Adder
  always_comb begin
    add_sum_d = add_sum_q;
    if (add_en) begin
      add_sum_d = add_a + add_b;
    end
  end

  // ALU
  logic [31:0] alu_res;
  logic        alu_illegal;
  logic [4:0]  shamt;

  always_comb begin
    shamt       = alu_b[4:0];
    alu_res     = 32'd0;
    alu_illegal = 1'b0;
    case (alu_op)
      5'd0:    alu_res = alu_a + alu_b;
      5'd1:    alu_res = alu_a - alu_b;
      5'd2:    alu_res = alu_a << shamt;
      5'd3:    alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      5'd4:    alu_res = {31'd0, alu_a < alu_b};
      5'd5:    alu_res = alu_a ^ alu_b;
      5'd6:    alu_res = alu_a >> shamt;
      5'd7:    alu_res = 32'($signed(alu_a) >>> shamt);
      5'd8:    alu_res = alu_a | alu_b;
      5'd9:    alu_res = alu_a & alu_b;
      5'd10:   alu_res = {31'd0, alu_a == alu_b};
      5'd11:   alu_res = {31'd0, alu_a != alu_b};
      5'd12:   alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      5'd13:   alu_res = {31'd0, $signed(alu_a) >= $signed(alu_b)};
      5'd14:   alu_res = {31'd0, alu_a < alu_b};
      5'd15:   alu_res = {31'd0, alu_a >= alu_b};
      default: alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    alu_out_d   = alu_out_q;
    alu_fault_d = alu_fault_q;
    if (alu_en) begin
      alu_out_d   = alu_res;
      alu_fault_d = alu_illegal;
    end
  end

  // CSR address decode; read-only ID registers are hard-wired to zero
  logic [31:0] csr_old;
  logic        csr_known;
  logic        csr_ro;

  always_comb begin
    csr_old   = 32'd0;
    csr_known = 1'b1;
    csr_ro    = 1'b0;
    case (csr_addr)
      12'h300: csr_old = mstatus_q;
      12'h304: csr_old = mie_q;
      12'h305: csr_old = mtvec_q;
      12'h340: csr_old = mscratch_q;
      12'h341: csr_old = mepc_q;
      12'h342: csr_old = mcause_q;
      12'h343: csr_old = mtval_q;
      12'hF11, 12'hF12, 12'hF13, 12'hF14: csr_ro = 1'b1;
      default: csr_known = 1'b0;
    endcase
  end

  logic [31:0] csr_new;
  logic        csr_legal;
  logic        csr_wr;

  always_comb begin
    csr_new = csr_old;
    case (csr_op)
      CSR_WRITE: csr_new = csr_in;
      CSR_SET:   csr_new = csr_old | csr_in;
      CSR_CLEAR: csr_new = csr_old & ~csr_in;
      default:   csr_new = csr_old;
    endcase
    csr_legal = csr_known && !csr_op[2] && !(csr_ro && (csr_op != CSR_READ));
    csr_wr    = csr_en && csr_legal && (csr_op != CSR_READ);
  end

  always_comb begin
    csr_rd_d    = csr_rd_q;
    csr_fault_d = csr_fault_q;
    mstatus_d   = mstatus_q;
    mie_d       = mie_q;
    mtvec_d     = mtvec_q;
    mscratch_d  = mscratch_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    mtval_d     = mtval_q;
    if (csr_en) begin
      csr_rd_d    = csr_legal ? csr_old : 32'd0;
      csr_fault_d = !csr_legal;
    end
    if (csr_wr) begin
      case (csr_addr)
        12'h300: mstatus_d  = csr_new;
        12'h304: mie_d      = csr_new;
        12'h305: mtvec_d    = csr_new;
        12'h340: mscratch_d = csr_new;
        12'h341: mepc_d     = csr_new;
        12'h342: mcause_d   = csr_new;
        12'h343: mtval_d    = csr_new;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      add_sum_q   <= 32'd0;
      alu_out_q   <= 32'd0;
      alu_fault_q <= 1'b0;
      csr_rd_q    <= 32'd0;
      csr_fault_q <= 1'b0;
      mstatus_q   <= 32'd0;
      mie_q       <= 32'd0;
      mtvec_q     <= 32'd0;
      mscratch_q  <= 32'd0;
      mepc_q      <= 32'd0;
      mcause_q    <= 32'd0;
      mtval_q     <= 32'd0;
    end else begin
      add_sum_q   <= add_sum_d;
      alu_out_q   <= alu_out_d;
      alu_fault_q <= alu_fault_d;
      csr_rd_q    <= csr_rd_d;
      csr_fault_q <= csr_fault_d;
      mstatus_q   <= mstatus_d;
      mie_q       <= mie_d;
      mtvec_q     <= mtvec_d;
      mscratch_q  <= mscratch_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      mtval_q     <= mtval_d;
    end
  end

  assign add_sum        = add_sum_q;
  assign alu_out        = alu_out_q;
  assign alu_fault      = alu_fault_q;
  assign csr_read_value = csr_rd_q;
  assign csr_fault      = csr_fault_q;
  assign fault          = alu_fault_q | csr_fault_q;

endmodule

// File: tb/tb_exec_datapath.sv
// tb/tb_exec_datapath.sv - directed self-checking bench for exec_datapath
module tb_exec_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        add_en;
  logic [31:0] add_a, add_b, add_sum;
  logic        alu_en;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_fault;
  logic        csr_en;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_in, csr_read_value;
  logic        csr_fault, fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exec_datapath dut (
    .clk(clk), .reset(reset),
    .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_fault(alu_fault),
    .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr), .csr_in(csr_in),
    .csr_read_value(csr_read_value), .csr_fault(csr_fault), .fault(fault)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_en = 1'b1; alu_op = op; alu_a = a; alu_b = b;
    tick();
    alu_en = 1'b0;
  endtask

  task automatic csr(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] din);
    csr_en = 1'b1; csr_op = op; csr_addr = addr; csr_in = din;
    tick();
    csr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    add_en = 0; add_a = 0; add_b = 0;
    alu_en = 0; alu_op = 0; alu_a = 0; alu_b = 0;
    csr_en = 0; csr_op = 0; csr_addr = 0; csr_in = 0;
    tick(); tick();
    reset = 1'b0;
    check_eq("rst_add_sum", add_sum, 0);
    check_eq("rst_alu_out", alu_out, 0);
    check_eq("rst_csr_rd", csr_read_value, 0);
    check_eq("rst_fault", {29'd0, alu_fault, csr_fault, fault}, 0);

    // Adder wrap and hold
    add_en = 1; add_a = 32'hFFFF_FFFC; add_b = 32'd4;
    tick();
    check_eq("add_wrap", add_sum, 0);
    add_en = 0; add_a = 32'd100; add_b = 32'd23;
    tick();
    check_eq("add_hold", add_sum, 0);
    add_en = 1;
    tick();
    add_en = 0;
    check_eq("add_123", add_sum, 32'd123);

    // ALU arithmetic / shift
    alu(5'd1, 32'd5, 32'd7);             check_eq("sub", alu_out, 32'hFFFF_FFFE);
    alu(5'd7, 32'h8000_0000, 32'h21);    check_eq("sra", alu_out, 32'hC000_0000);
    alu(5'd6, 32'h8000_0000, 32'h21);    check_eq("srl", alu_out, 32'h4000_0000);
    alu(5'd2, 32'h0000_0003, 32'h24);    check_eq("sll", alu_out, 32'h0000_0030);
    alu(5'd5, 32'hF0F0_F0F0, 32'hFF00_FF00); check_eq("xor", alu_out, 32'h0FF0_0FF0);
    alu(5'd9, 32'hF0F0_F0F0, 32'hFF00_FF00); check_eq("and", alu_out, 32'hF000_F000);
    alu(5'd8, 32'hF0F0_F0F0, 32'h0F00_0000); check_eq("or", alu_out, 32'hFFF0_F0F0);
    alu_a = 32'd9; alu_b = 32'd9; alu_op = 5'd0;
    tick();
    check_eq("alu_hold", alu_out, 32'hFFF0_F0F0);

    // ALU compare
    alu(5'd3,  32'hFFFF_FFFF, 32'd1);    check_eq("slt", alu_out, 32'd1);
    alu(5'd4,  32'hFFFF_FFFF, 32'd1);    check_eq("sltu", alu_out, 32'd0);
    alu(5'd13, 32'd5, 32'd5);            check_eq("ge", alu_out, 32'd1);
    alu(5'd11, 32'd3, 32'd3);            check_eq("ne", alu_out, 32'd0);
    alu(5'd10, 32'd3, 32'd3);            check_eq("eq", alu_out, 32'd1);
    alu(5'd12, 32'h8000_0000, 32'd0);    check_eq("lt", alu_out, 32'd1);
    alu(5'd14, 32'h8000_0000, 32'd0);    check_eq("ltu", alu_out, 32'd0);
    alu(5'd15, 32'h8000_0000, 32'd0);    check_eq("geu", alu_out, 32'd1);

    // ALU illegal op, then recovery
    alu(5'd20, 32'd7, 32'd8);
    check_eq("ill_alu_out", alu_out, 0);
    check_eq("ill_alu_fault", {31'd0, alu_fault}, 1);
    check_eq("ill_fault", {31'd0, fault}, 1);
    tick();
    check_eq("ill_fault_latched", {31'd0, alu_fault}, 1);
    alu(5'd0, 32'd1, 32'd2);
    check_eq("add_after_ill", alu_out, 32'd3);
    check_eq("alu_fault_clr", {30'd0, alu_fault, fault}, 0);

    // CSR sequence on mscratch
    csr(3'b001, 12'h340, 32'h1234_5678); check_eq("csr_write", csr_read_value, 0);
    csr(3'b010, 12'h340, 32'h0000_000F); check_eq("csr_set", csr_read_value, 32'h1234_5678);
    csr(3'b011, 12'h340, 32'h0000_FFFF); check_eq("csr_clear", csr_read_value, 32'h1234_567F);
    csr(3'b000, 12'h340, 32'hFFFF_FFFF); check_eq("csr_read", csr_read_value, 32'h1234_0000);
    csr(3'b001, 12'h305, 32'h0000_0100); check_eq("mtvec_wr", csr_read_value, 0);
    csr(3'b000, 12'h305, 32'd0);         check_eq("mtvec_rd", csr_read_value, 32'h0000_0100);
    tick();
    check_eq("csr_hold", csr_read_value, 32'h0000_0100);

    // CSR faults
    csr(3'b001, 12'hF14, 32'hFFFF_FFFF);
    check_eq("ro_wr_fault", {30'd0, csr_fault, fault}, 32'd3);
    check_eq("ro_wr_rd", csr_read_value, 0);
    csr(3'b000, 12'hF14, 32'd0);
    check_eq("ro_rd", csr_read_value, 0);
    check_eq("ro_rd_fault", {30'd0, csr_fault, fault}, 0);
    csr(3'b000, 12'h7C0, 32'd0);
    check_eq("unk_addr_fault", {31'd0, csr_fault}, 1);
    csr(3'b000, 12'h340, 32'd0);
    check_eq("csr_fault_clr", {31'd0, csr_fault}, 0);
    csr(3'b101, 12'h340, 32'hFFFF_FFFF);
    check_eq("ill_op_fault", {31'd0, csr_fault}, 1);
    check_eq("ill_op_rd", csr_read_value, 0);
    csr(3'b000, 12'h340, 32'd0);
    check_eq("ill_op_nochg", csr_read_value, 32'h1234_0000);

    // Simultaneous enables, then reset overriding all of them
    add_en = 1; add_a = 32'd10; add_b = 32'd20;
    alu_en = 1; alu_op = 5'd1; alu_a = 32'd50; alu_b = 32'd8;
    csr_en = 1; csr_op = 3'b000; csr_addr = 12'h305; csr_in = 0;
    tick();
    check_eq("sim_add", add_sum, 32'd30);
    check_eq("sim_alu", alu_out, 32'd42);
    check_eq("sim_csr", csr_read_value, 32'h0000_0100);
    alu_op = 5'd25; csr_op = 3'b001; csr_addr = 12'h340; csr_in = 32'hDEAD_BEEF;
    reset = 1;
    tick();
    reset = 0; add_en = 0; alu_en = 0; csr_en = 0;
    check_eq("rst_add", add_sum, 0);
    check_eq("rst_alu", alu_out, 0);
    check_eq("rst_csr", csr_read_value, 0);
    check_eq("rst_faults", {29'd0, alu_fault, csr_fault, fault}, 0);
    csr(3'b000, 12'h340, 32'd0);
    check_eq("rst_mscratch", csr_read_value, 0);
    csr(3'b000, 12'h305, 32'd0);
    check_eq("rst_mtvec", csr_read_value, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
